lcd_frame_scheduler: RTL
========================

# lcd_frame_scheduler

Sequencer that streams a complete frame from an external frame-buffer RAM into `lcd_encoder`, one byte per transfer. It also issues display start-line (scroll) updates between frames. It sits between the frame-buffer and `lcd_encoder` and owns the encoder's `data_busy`/`instr_busy` handshake.

## Interface
Parameters:
- `FRAME_GAP`, default 0: idle cycles inserted after `frame_done` before an auto-refresh restart.

Ports. Widths use `lcd.vh` macros. Clock: `clk_lcd`. Reset: `reset_n`, asynchronous, active-low.
- `clk_lcd` in 1: sole clock.
- `reset_n` in 1: asynchronous active-low reset.
- `refresh_start` in 1: one-cycle pulse; starts one frame.
- `auto_refresh` in 1: level; restart frames continuously.
- `start_line_req` in 1: one-cycle pulse; requests a scroll update.
- `start_line_in` in `LCD_ROW_COUNT_BIT_WIDTH`: scroll value, sampled with `start_line_req`.
- `fb_rd_en` out 1: frame-buffer read strobe.
- `fb_rd_addr` out `LCD_ADDR_X_COUNT_BIT_WIDTH + LCD_ADDR_Y_COUNT_BIT_WIDTH`: read address `{x, y}`.
- `fb_rd_data` in `LCD_DATA_BIT_WIDTH`: read data, valid exactly one cycle after `fb_rd_en`.
- `data_write`, `start_line_write`, `addr_y`, `addr_x`, `data_action`, `data_busy` out: drive the matching `lcd_encoder` inputs.
- `instr_busy` in 1: from `lcd_encoder`.
- `frame_busy` out 1: high from frame start to `frame_done`.
- `frame_done` out 1: one-cycle pulse after the last byte completes.

## Operation
- Reset values:
  - `data_busy`=1 (mandatory: the encoder clears `instr_busy` only while `data_busy`=1).
  - `data_action`=`LCD_DATA_ACTION_WRITE_DATA`.
  - All other outputs 0; cursor x=y=0; scroll-pending=0; state IDLE.
- Handshake for one transfer:
  - Hold `data_busy`=1 while loading fields.
  - Drop `data_busy` to 0 to issue.
  - Acceptance is `instr_busy` rising. The next cycle, raise `data_busy` to 1; fields stay frozen.
  - Completion is `instr_busy`=0 while `data_busy`=1.
- States:
  - IDLE: `data_busy`=1. Wait `instr_busy`=0, which also covers the encoder's post-reset init. Then:
    - pending scroll → SCROLL;
    - otherwise `refresh_start` or `auto_refresh` → FETCH.
  - FETCH: `fb_rd_en`=1, `fb_rd_addr`={x,y} → LOAD.
  - LOAD: `data_write`←`fb_rd_data`, `addr_x`←x, `addr_y`←y, `data_action`←WRITE_DATA → ISSUE.
  - SCROLL: `start_line_write`←pending value, `data_action`←WRITE_DISPLAY_START_LINE, clear pending → ISSUE.
  - ISSUE: `data_busy`=0. On `instr_busy`=1 → `data_busy`←1, go to WAIT_DONE.
  - WAIT_DONE: on `instr_busy`=0:
    - after a scroll → IDLE;
    - after a byte, advance cursor; if last byte → pulse `frame_done`, go to GAP;
    - otherwise → FETCH.
  - GAP: count `FRAME_GAP` cycles → IDLE.
- Cursor:
  - y counts 0..`LCD_ADDR_Y_COUNT`-1, then wraps to 0 and x increments.
  - Last byte is x=`LCD_ADDR_X_COUNT`-1 with y at its maximum. After it, both wrap to 0.
- Request rules:
  - `refresh_start` outside IDLE is ignored.
  - `start_line_req` is always latched; last value wins. It is served only in IDLE, so scrolls never tear a frame.
  - In IDLE, a pending scroll has priority over a refresh. Simultaneous `start_line_req` and `refresh_start` in IDLE: the scroll is latched, the refresh is dropped.
- `frame_busy` is 1 in FETCH through WAIT_DONE of a frame. It is 0 in IDLE, GAP and scroll transfers.
- `reset_n` low mid-frame: immediate return to reset values; no `frame_done`.

## Timing
- `refresh_start` sampled at cycle 0 in IDLE with `instr_busy`=0:
  - FETCH at cycle 1;
  - LOAD at cycle 2;
  - `data_busy`=0 from cycle 3.
- Acceptance to `data_busy`=1: 1 cycle.
- Completion to next FETCH: 1 cycle.
- Scheduler overhead: 4 cycles per byte, plus encoder execution time.
- `frame_done` is asserted in the cycle after the final completion is detected.

## Structure
- Add state encodings to `lcd.vh`: `LCD_SCHED_STATE_*` and `LCD_SCHED_STATE_BIT_WIDTH`.
- Reuse the existing `LCD_DATA_ACTION_*` and width macros.
- One natural sub-module, `lcd_frame_cursor`: the x/y counter with `advance` and `clear` inputs and `last` and `x`/`y` outputs.
- Top-level bench pairs the block with `lcd_encoder` plus a behavioural frame-buffer.

## Test plan
- Reset release with encoder init: `data_busy` stays 1 until `instr_busy` falls; `refresh_start` then yields FETCH at +1 and `data_busy`=0 at +3.
- Full frame with fb byte = `{x, y[4:0]}`: the encoder sees exactly `LCD_ADDR_X_COUNT`×`LCD_ADDR_Y_COUNT` writes in y-then-x order with correct data; one `frame_done`; cursor back at 0,0.
- `start_line_req` with value 5 mid-frame: no scroll until `frame_done`; then exactly one START_LINE action with `start_line_write`=5.
- Two scroll requests (3, then 9) mid-frame: a single update with 9.
- `auto_refresh`=1, `FRAME_GAP`=4: the next FETCH is 5 cycles after `frame_done` (4 in GAP, 1 in IDLE) when `instr_busy`=0.
- `reset_n` asserted during ISSUE: all outputs return to reset values asynchronously; no `frame_done`; a clean frame follows after the next `refresh_start`.

Source files
------------

// File: rtl/lcd_frame_scheduler_pkg.sv
// Shared widths, data-action codes, scheduler state encodings and the frame-buffer address payload.
package lcd_frame_scheduler_pkg;

  localparam int unsigned LCD_DATA_BIT_WIDTH         = 8;
  localparam int unsigned LCD_ADDR_X_COUNT           = 8;
  localparam int unsigned LCD_ADDR_X_COUNT_BIT_WIDTH = 3;
  localparam int unsigned LCD_ADDR_Y_COUNT           = 64;
  localparam int unsigned LCD_ADDR_Y_COUNT_BIT_WIDTH = 6;
  localparam int unsigned LCD_ROW_COUNT_BIT_WIDTH    = 6;
  localparam int unsigned LCD_DATA_ACTION_BIT_WIDTH  = 2;

  localparam logic [LCD_DATA_ACTION_BIT_WIDTH-1:0] LCD_DATA_ACTION_WRITE_DATA               = 2'd0;
  localparam logic [LCD_DATA_ACTION_BIT_WIDTH-1:0] LCD_DATA_ACTION_WRITE_DISPLAY_START_LINE = 2'd1;

  localparam int unsigned LCD_SCHED_STATE_BIT_WIDTH = 3;
  localparam logic [LCD_SCHED_STATE_BIT_WIDTH-1:0] LCD_SCHED_STATE_IDLE      = 3'd0;
  localparam logic [LCD_SCHED_STATE_BIT_WIDTH-1:0] LCD_SCHED_STATE_FETCH     = 3'd1;
  localparam logic [LCD_SCHED_STATE_BIT_WIDTH-1:0] LCD_SCHED_STATE_LOAD      = 3'd2;
  localparam logic [LCD_SCHED_STATE_BIT_WIDTH-1:0] LCD_SCHED_STATE_SCROLL    = 3'd3;
  localparam logic [LCD_SCHED_STATE_BIT_WIDTH-1:0] LCD_SCHED_STATE_ISSUE     = 3'd4;
  localparam logic [LCD_SCHED_STATE_BIT_WIDTH-1:0] LCD_SCHED_STATE_WAIT_DONE = 3'd5;
  localparam logic [LCD_SCHED_STATE_BIT_WIDTH-1:0] LCD_SCHED_STATE_GAP       = 3'd6;

  typedef struct packed {
    logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0] x;
    logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0] y;
  } lcd_fb_addr_t;

endpackage

// File: rtl/lcd_frame_cursor.sv
// Frame cursor: y runs fastest, x steps when y wraps; 'last' flags the final byte of the frame.
module lcd_frame_cursor
  import lcd_frame_scheduler_pkg::*;
(
  input  logic                                  clk_lcd,
  input  logic                                  reset_n,
  input  logic                                  advance,
  input  logic                                  clear,
  output logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0] x,
  output logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0] y,
  output logic                                  last
);

  localparam logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0] X_MAX = LCD_ADDR_X_COUNT_BIT_WIDTH'(LCD_ADDR_X_COUNT - 1);
  localparam logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0] Y_MAX = LCD_ADDR_Y_COUNT_BIT_WIDTH'(LCD_ADDR_Y_COUNT - 1);

  logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0] x_d;
  logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0] y_d;

  always_comb begin
    x_d = x;
    y_d = y;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (y == Y_MAX) begin
        y_d = '0;
        x_d = (x == X_MAX) ? '0 : x + 1'b1;
      end else begin
        y_d = y + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_lcd or negedge reset_n) begin
    if (!reset_n) begin
      x    <= '0;
      y    <= '0;
      last <= 1'b0;
    end else begin
      x    <= x_d;
      y    <= y_d;
      last <= (x_d == X_MAX) && (y_d == Y_MAX);
    end
  end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Streams a frame from the frame-buffer into lcd_encoder one byte per transfer and
// slots display start-line updates in between frames.
module lcd_frame_scheduler
  import lcd_frame_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_GAP = 0
) (
  input  logic                                                         clk_lcd,
  input  logic                                                         reset_n,
  input  logic                                                         refresh_start,
  input  logic                                                         auto_refresh,
  input  logic                                                         start_line_req,
  input  logic [LCD_ROW_COUNT_BIT_WIDTH-1:0]                           start_line_in,
  output logic                                                         fb_rd_en,
  output logic [LCD_ADDR_X_COUNT_BIT_WIDTH+LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0] fb_rd_addr,
  input  logic [LCD_DATA_BIT_WIDTH-1:0]                                fb_rd_data,
  output logic [LCD_DATA_BIT_WIDTH-1:0]                                data_write,
  output logic [LCD_ROW_COUNT_BIT_WIDTH-1:0]                           start_line_write,
  output logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0]                        addr_y,
  output logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0]                        addr_x,
  output logic [LCD_DATA_ACTION_BIT_WIDTH-1:0]                         data_action,
  output logic                                                         data_busy,
  input  logic                                                         instr_busy,
  output logic                                                         frame_busy,
  output logic                                                         frame_done
);

  localparam int unsigned GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  logic [LCD_SCHED_STATE_BIT_WIDTH-1:0] state, state_d;
  logic                                 scroll_pending, scroll_pending_d;
  logic [LCD_ROW_COUNT_BIT_WIDTH-1:0]   scroll_value, scroll_value_d;
  logic [GAP_W-1:0]                     gap_cnt, gap_cnt_d;

  logic                                  fb_rd_en_d, data_busy_d, frame_busy_d, frame_done_d;
  logic [LCD_DATA_BIT_WIDTH-1:0]         data_write_d;
  logic [LCD_ROW_COUNT_BIT_WIDTH-1:0]    start_line_write_d;
  logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0] addr_y_d;
  logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0] addr_x_d;
  logic [LCD_DATA_ACTION_BIT_WIDTH-1:0]  data_action_d;

  logic                                  advance_c, clear_c;
  logic [LCD_ADDR_X_COUNT_BIT_WIDTH-1:0] cur_x;
  logic [LCD_ADDR_Y_COUNT_BIT_WIDTH-1:0] cur_y;
  logic                                  cur_last;
  lcd_fb_addr_t                          rd_addr;

  lcd_frame_cursor u_cursor (
    .clk_lcd (clk_lcd),
    .reset_n (reset_n),
    .advance (advance_c),
    .clear   (clear_c),
    .x       (cur_x),
    .y       (cur_y),
    .last    (cur_last)
  );

  // Cursor flops drive the read address directly, so it is already advanced when FETCH begins.
  assign rd_addr    = '{x: cur_x, y: cur_y};
  assign fb_rd_addr = rd_addr;

  always_comb begin
    state_d            = state;
    scroll_pending_d   = scroll_pending;
    scroll_value_d     = scroll_value;
    gap_cnt_d          = gap_cnt;
    fb_rd_en_d         = 1'b0;
    frame_done_d       = 1'b0;
    data_busy_d        = data_busy;
    frame_busy_d       = frame_busy;
    data_write_d       = data_write;
    start_line_write_d = start_line_write;
    addr_y_d           = addr_y;
    addr_x_d           = addr_x;
    data_action_d      = data_action;
    advance_c          = 1'b0;
    clear_c            = 1'b0;

    case (state)
      LCD_SCHED_STATE_IDLE: begin
        // A scroll arriving this cycle claims the slot, so a coincident refresh is dropped.
        if (!instr_busy) begin
          if (scroll_pending) begin
            state_d = LCD_SCHED_STATE_SCROLL;
          end else if (!start_line_req && (refresh_start || auto_refresh)) begin
            state_d      = LCD_SCHED_STATE_FETCH;
            fb_rd_en_d   = 1'b1;
            frame_busy_d = 1'b1;
            clear_c      = 1'b1;
          end
        end
      end
      LCD_SCHED_STATE_FETCH: state_d = LCD_SCHED_STATE_LOAD;
      LCD_SCHED_STATE_LOAD: begin
        data_write_d  = fb_rd_data;
        addr_x_d      = cur_x;
        addr_y_d      = cur_y;
        data_action_d = LCD_DATA_ACTION_WRITE_DATA;
        data_busy_d   = 1'b0;
        state_d       = LCD_SCHED_STATE_ISSUE;
      end
      LCD_SCHED_STATE_SCROLL: begin
        start_line_write_d = scroll_value;
        data_action_d      = LCD_DATA_ACTION_WRITE_DISPLAY_START_LINE;
        scroll_pending_d   = 1'b0;
        data_busy_d        = 1'b0;
        state_d            = LCD_SCHED_STATE_ISSUE;
      end
      LCD_SCHED_STATE_ISSUE: begin
        if (instr_busy) begin
          data_busy_d = 1'b1;
          state_d     = LCD_SCHED_STATE_WAIT_DONE;
        end
      end
      LCD_SCHED_STATE_WAIT_DONE: begin
        if (!instr_busy) begin
          if (data_action == LCD_DATA_ACTION_WRITE_DISPLAY_START_LINE) begin
            state_d = LCD_SCHED_STATE_IDLE;
          end else begin
            advance_c = 1'b1;
            if (cur_last) begin
              frame_done_d = 1'b1;
              frame_busy_d = 1'b0;
              gap_cnt_d    = '0;
              state_d      = (FRAME_GAP == 0) ? LCD_SCHED_STATE_IDLE : LCD_SCHED_STATE_GAP;
            end else begin
              fb_rd_en_d = 1'b1;
              state_d    = LCD_SCHED_STATE_FETCH;
            end
          end
        end
      end
      LCD_SCHED_STATE_GAP: begin
        if (gap_cnt == GAP_W'(FRAME_GAP - 1)) begin
          state_d = LCD_SCHED_STATE_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = LCD_SCHED_STATE_IDLE;
    endcase

    // Latched after the SCROLL clear so a request in that same cycle is not lost.
    if (start_line_req) begin
      scroll_pending_d = 1'b1;
      scroll_value_d   = start_line_in;
    end
  end

  always_ff @(posedge clk_lcd or negedge reset_n) begin
    if (!reset_n) begin
      state            <= LCD_SCHED_STATE_IDLE;
      scroll_pending   <= 1'b0;
      scroll_value     <= '0;
      gap_cnt          <= '0;
      fb_rd_en         <= 1'b0;
      data_busy        <= 1'b1;
      frame_busy       <= 1'b0;
      frame_done       <= 1'b0;
      data_write       <= '0;
      start_line_write <= '0;
      addr_y           <= '0;
      addr_x           <= '0;
      data_action      <= LCD_DATA_ACTION_WRITE_DATA;
    end else begin
      state            <= state_d;
      scroll_pending   <= scroll_pending_d;
      scroll_value     <= scroll_value_d;
      gap_cnt          <= gap_cnt_d;
      fb_rd_en         <= fb_rd_en_d;
      data_busy        <= data_busy_d;
      frame_busy       <= frame_busy_d;
      frame_done       <= frame_done_d;
      data_write       <= data_write_d;
      start_line_write <= start_line_write_d;
      addr_y           <= addr_y_d;
      addr_x           <= addr_x_d;
      data_action      <= data_action_d;
    end
  end

endmodule
